// File: rtl/spi_sclk_gen.sv
// SPI serial-clock burst generator: sclk_o with CPOL/CPHA, sample/shift strobes, bit index and done pulse.
// Latency: edge k is visible at t+1+k*(div+1) after the start cycle t; every output is registered.
// Backpressure: none; start_i is taken only in IDLE, stop_i aborts a burst. Optional macro SPI_SCLK_CS_EN adds cs_no.
module spi_sclk_gen #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             cpol_i,
  input  logic             cpha_i,
  input  logic [CNT_W-1:0] nbits_i,
  output logic             busy_o,
  output logic             sclk_o,
  output logic             sample_o,
  output logic             shift_o,
  output logic             done_o,
  output logic [CNT_W-1:0] bit_idx_o
`ifdef SPI_SCLK_CS_EN
  ,
  output logic             cs_no
`endif
);

  // Tick counter covers 2N edges plus lead/tail ticks, so it needs two bits more than the bit count.
  localparam int TK_W = CNT_W + 2;

`ifdef SPI_SCLK_CS_EN
  // One idle half-period before edge 1. After the last edge sclk keeps its idle level for that
  // edge's own half-period and then one further hold half-period before chip select is released.
  localparam logic [TK_W-1:0] LEAD_TK = TK_W'(1);
  localparam logic [TK_W-1:0] TAIL_TK = TK_W'(3);
`else
  localparam logic [TK_W-1:0] LEAD_TK = TK_W'(0);
  localparam logic [TK_W-1:0] TAIL_TK = TK_W'(0);
`endif

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic             cpol_q;
  logic             cpha_q;
  logic [CNT_W-1:0] nbits_q;
  logic [TK_W-1:0]  tk_q;

  logic             tick;
  logic [TK_W-1:0]  tk_nxt;
  logic [TK_W-1:0]  edge_num;
  logic [TK_W-1:0]  edges_total;
  logic             is_edge;
  logic             is_lead;
  logic             is_last_edge;
  logic             is_end;
  logic [CNT_W-1:0] nbits_eff;

  // Decode what the upcoming tick means: which edge it is, whether it is the last one, whether the burst ends.
  always_comb begin
    tick         = (cnt_q == div_q);
    tk_nxt       = tk_q + TK_W'(1);
    edge_num     = tk_nxt - LEAD_TK;
    edges_total  = {1'b0, nbits_q, 1'b0};
    is_edge      = (tk_nxt > LEAD_TK) && (edge_num <= edges_total);
    is_lead      = edge_num[0];
    is_last_edge = (edge_num == edges_total);
    is_end       = (tk_nxt == (edges_total + TAIL_TK));
    nbits_eff    = (nbits_i == '0) ? CNT_W'(1) : nbits_i;
  end

  // Two-state burst FSM; strobes default low and are raised only in the cycle before their edge shows.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      nbits_q   <= '0;
      tk_q      <= '0;
      busy_o    <= 1'b0;
      sclk_o    <= 1'b0;
      sample_o  <= 1'b0;
      shift_o   <= 1'b0;
      done_o    <= 1'b0;
      bit_idx_o <= '0;
`ifdef SPI_SCLK_CS_EN
      cs_no     <= 1'b1;
`endif
    end else begin
      sample_o <= 1'b0;
      shift_o  <= 1'b0;
      done_o   <= 1'b0;
      case (state_q)
        IDLE: begin
          sclk_o <= cpol_i;
          if (start_i && !stop_i) begin
            div_q     <= div_i;
            cpol_q    <= cpol_i;
            cpha_q    <= cpha_i;
            nbits_q   <= nbits_eff;
            cnt_q     <= '0;
            tk_q      <= '0;
            bit_idx_o <= '0;
            busy_o    <= 1'b1;
            state_q   <= RUN;
`ifdef SPI_SCLK_CS_EN
            cs_no     <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (stop_i) begin
            // Abort: park sclk at its idle level, no done and no strobes.
            state_q <= IDLE;
            sclk_o  <= cpol_q;
            busy_o  <= 1'b0;
            cnt_q   <= '0;
`ifdef SPI_SCLK_CS_EN
            cs_no   <= 1'b1;
`endif
          end else if (tick) begin
            cnt_q <= '0;
            tk_q  <= tk_nxt;
            if (is_edge) begin
              sclk_o <= ~sclk_o;
              if (is_lead) begin
                if (cpha_q) shift_o <= 1'b1;
                else        sample_o <= 1'b1;
              end else begin
                bit_idx_o <= bit_idx_o + CNT_W'(1);
                if (cpha_q)             sample_o <= 1'b1;
                else if (!is_last_edge) shift_o  <= 1'b1;
              end
            end
            if (is_end) begin
              done_o  <= 1'b1;
              busy_o  <= 1'b0;
              state_q <= IDLE;
`ifdef SPI_SCLK_CS_EN
              cs_no   <= 1'b1;
`endif
            end
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed bench for spi_sclk_gen: table of whole transfers plus hand sequences for stop, back-to-back and reset.
// Inputs change 1 time unit after the rising edge; outputs are read at that same point, clear of the edge.
// Cycle offsets are counted from the start cycle t, so the first read after start_i is sampled is t+1.
module tb_spi_sclk_gen;

`ifdef SPI_SCLK_CS_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic        stop_i;
  logic [15:0] div_i;
  logic        cpol_i;
  logic        cpha_i;
  logic [7:0]  nbits_i;
  logic        busy_o;
  logic        sclk_o;
  logic        sample_o;
  logic        shift_o;
  logic        done_o;
  logic [7:0]  bit_idx_o;
`ifdef SPI_SCLK_CS_EN
  logic        cs_no;
`endif

  spi_sclk_gen #(.DIV_W(16), .CNT_W(8)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .div_i     (div_i),
    .cpol_i    (cpol_i),
    .cpha_i    (cpha_i),
    .nbits_i   (nbits_i),
    .busy_o    (busy_o),
    .sclk_o    (sclk_o),
    .sample_o  (sample_o),
    .shift_o   (shift_o),
    .done_o    (done_o),
    .bit_idx_o (bit_idx_o)
`ifdef SPI_SCLK_CS_EN
    ,
    .cs_no     (cs_no)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        cpol;
    logic        cpha;
    logic [15:0] div;
    logic [7:0]  nbits;
    int          first_edge;  // offset of first sclk change without the chip-select lead
    int          done_at;     // offset of done_o without the chip-select lead/hold
    int          n_sample;
    int          n_shift;
    int          idx;
  } vec_t;

  vec_t        vecs [5];
  int          checks;
  int          errors;
  logic [63:0] last_samp_mask;
  logic [63:0] last_shift_mask;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one transfer and returns while the done_o cycle is still current.
  task automatic run_and_check(input vec_t v, input string tag);
    int   m;
    int   first;
    int   done_at;
    int   ns;
    int   nsh;
    int   toggles;
    int   both;
    int   n_eff;
    int   hp;
    logic prev;
    logic seen;
    cpol_i  = v.cpol;
    cpha_i  = v.cpha;
    div_i   = v.div;
    nbits_i = v.nbits;
    step();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk({tag, " busy_t+1"}, 64'(busy_o), 64'd1);
`ifdef SPI_SCLK_CS_EN
    chk({tag, " cs_no_t+1"}, 64'(cs_no), 64'd0);
`endif
    m = 1; first = -1; done_at = -1; ns = 0; nsh = 0; toggles = 0; both = 0;
    prev = v.cpol; seen = 1'b0;
    last_samp_mask = '0; last_shift_mask = '0;
    while (!seen && m < 400) begin
      if (sclk_o != prev) toggles++;
      prev = sclk_o;
      if (first < 0 && sclk_o != v.cpol) first = m;
      if (sample_o) begin ns++;  if (m < 64) last_samp_mask[m] = 1'b1;  end
      if (shift_o)  begin nsh++; if (m < 64) last_shift_mask[m] = 1'b1; end
      if (sample_o && shift_o) both++;
      if (done_o) begin
        seen    = 1'b1;
        done_at = m;
      end else begin
        step();
        m++;
      end
    end
    hp    = int'(v.div) + 1;
    n_eff = (v.nbits == 0) ? 1 : int'(v.nbits);
    chk({tag, " done_seen"}, 64'(seen), 64'd1);
    chk({tag, " first_edge"}, 64'(first), 64'(v.first_edge + CS * hp));
    chk({tag, " done_at"}, 64'(done_at), 64'(v.done_at + 3 * CS * hp));
    chk({tag, " n_sample"}, 64'(ns), 64'(v.n_sample));
    chk({tag, " n_shift"}, 64'(nsh), 64'(v.n_shift));
    chk({tag, " toggles"}, 64'(toggles), 64'(2 * n_eff));
    chk({tag, " sample_and_shift"}, 64'(both), 64'd0);
    chk({tag, " bit_idx_at_done"}, 64'(bit_idx_o), 64'(v.idx));
    chk({tag, " busy_at_done"}, 64'(busy_o), 64'd0);
`ifdef SPI_SCLK_CS_EN
    chk({tag, " cs_no_at_done"}, 64'(cs_no), 64'd1);
`endif
  endtask

  initial begin
    int   m;
    int   d;
    logic seen;
    checks  = 0;
    errors  = 0;
    rst_ni  = 1'b0;
    start_i = 1'b0;
    stop_i  = 1'b0;
    div_i   = '0;
    cpol_i  = 1'b0;
    cpha_i  = 1'b0;
    nbits_i = '0;

    //            cpol  cpha  div    nbits first done samp shift idx
    vecs[0] = '{1'b0, 1'b0, 16'd1, 8'd8, 3,    33,  8,   7,    8};
    vecs[1] = '{1'b1, 1'b1, 16'd0, 8'd4, 2,    9,   4,   4,    4};
    vecs[2] = '{1'b0, 1'b0, 16'd2, 8'd0, 4,    7,   1,   0,    1};
    vecs[3] = '{1'b0, 1'b1, 16'd0, 8'd3, 2,    7,   3,   3,    3};
    vecs[4] = '{1'b1, 1'b0, 16'd3, 8'd2, 5,    17,  2,   1,    2};

    // Reset values
    step();
    step();
    chk("rst busy", 64'(busy_o), 64'd0);
    chk("rst sclk", 64'(sclk_o), 64'd0);
    chk("rst sample", 64'(sample_o), 64'd0);
    chk("rst shift", 64'(shift_o), 64'd0);
    chk("rst done", 64'(done_o), 64'd0);
    chk("rst bit_idx", 64'(bit_idx_o), 64'd0);
`ifdef SPI_SCLK_CS_EN
    chk("rst cs_no", 64'(cs_no), 64'd1);
`endif
    rst_ni = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      run_and_check(vecs[i], $sformatf("vec%0d", i));
    end

    // Mode 3 strobe positions, then start_i in its done cycle for a back-to-back burst
    run_and_check(vecs[1], "mode3");
    chk("mode3 sample_mask", last_samp_mask, 64'h2A8 << CS);
    chk("mode3 shift_mask", last_shift_mask, 64'h154 << CS);
    cpol_i  = 1'b0;
    cpha_i  = 1'b0;
    div_i   = 16'd1;
    nbits_i = 8'd2;
    start_i = 1'b1;
    step();
    chk("b2b busy", 64'(busy_o), 64'd1);
    // start_i held and config changed while busy must be ignored
    div_i   = 16'd7;
    nbits_i = 8'd9;
    step();
    start_i = 1'b0;
    d = 2; seen = 1'b0;
    while (!seen && d < 200) begin
      if (done_o) seen = 1'b1;
      else begin step(); d++; end
    end
    chk("b2b done_at", 64'(d), 64'(1 + (4 + 3 * CS) * 2));
    chk("b2b bit_idx", 64'(bit_idx_o), 64'd2);

    // stop_i during bit 3 of a cpol=1 transfer
    cpol_i  = 1'b1;
    cpha_i  = 1'b0;
    div_i   = 16'd1;
    nbits_i = 8'd8;
    step();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    m = 0;
    while (bit_idx_o != 8'd2 && m < 200) begin step(); m++; end
    chk("stop reached_bit3", 64'(bit_idx_o), 64'd2);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk("stop busy", 64'(busy_o), 64'd0);
    chk("stop sclk", 64'(sclk_o), 64'd1);
    chk("stop done", 64'(done_o), 64'd0);
    chk("stop strobes", 64'({sample_o, shift_o}), 64'd0);
`ifdef SPI_SCLK_CS_EN
    chk("stop cs_no", 64'(cs_no), 64'd1);
`endif
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done_o || busy_o) seen = 1'b1;
      step();
    end
    chk("stop stays_idle", 64'(seen), 64'd0);
    run_and_check(vecs[0], "after_stop");

    // start_i together with stop_i in IDLE starts nothing
    start_i = 1'b1;
    stop_i  = 1'b1;
    step();
    start_i = 1'b0;
    stop_i  = 1'b0;
    chk("start_stop busy", 64'(busy_o), 64'd0);
    step();
    step();
    chk("start_stop still_idle", 64'(busy_o), 64'd0);

    // Reset asserted mid-transfer acts without a clock edge
    cpol_i  = 1'b0;
    cpha_i  = 1'b0;
    div_i   = 16'd1;
    nbits_i = 8'd8;
    step();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 0; k < 11; k++) step();
    chk("mid pre_reset busy", 64'(busy_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst busy", 64'(busy_o), 64'd0);
    chk("mid_rst sclk", 64'(sclk_o), 64'd0);
    chk("mid_rst bit_idx", 64'(bit_idx_o), 64'd0);
    chk("mid_rst strobes", 64'({sample_o, shift_o, done_o}), 64'd0);
`ifdef SPI_SCLK_CS_EN
    chk("mid_rst cs_no", 64'(cs_no), 64'd1);
`endif
    step();
    rst_ni = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_sclk_gen.md
Name: spi_sclk_gen

Overview:
- Parametrised successor to the SPI prescaler clock-enable generator.
- Produces a complete SPI serial-clock burst from an internal divider: sclk_o with programmable CPOL/CPHA, single-cycle sample/shift strobes, a bit index, and a done pulse after a programmable bit count.
- Sits between the SPI register interface and the shift-register datapath; the datapath acts only on its strobes and never derives timing itself.

Parameters:
- DIV_W, 16, width of the half-period divider value div_i.
- CNT_W, 8, width of the bit count nbits_i and bit_idx_o.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  reset, asynchronous, active-low
- start_i  input  1  request a transfer; accepted only in IDLE
- stop_i  input  1  abort the current transfer
- div_i  input  DIV_W  half-period = div_i+1 clk_i cycles
- cpol_i  input  1  sclk idle level
- cpha_i  input  1  0: sample on leading edge; 1: sample on trailing edge
- nbits_i  input  CNT_W  bits per transfer; 0 is treated as 1
- busy_o  output  1  transfer in progress
- sclk_o  output  1  SPI serial clock
- sample_o  output  1  one-cycle strobe: capture MISO
- shift_o  output  1  one-cycle strobe: drive next MOSI bit
- done_o  output  1  one-cycle strobe: transfer complete
- bit_idx_o  output  CNT_W  completed bits in the current transfer

Behaviour:
- Clock is clk_i. Reset rst_ni is asynchronous, active-low.
- All outputs are registered. Reset values: busy_o=0, sclk_o=0, sample_o=0, shift_o=0, done_o=0, bit_idx_o=0. Divider count=0. FSM=IDLE.
- FSM has two states, IDLE and RUN.
- IDLE:
  - sclk_o <= cpol_i every cycle.
  - start_i=1 with stop_i=0 latches div_i, cpol_i, cpha_i and nbits_i (0 becomes 1), clears the divider and bit_idx_o, and moves to RUN.
  - busy_o=1 from the next cycle. Call the start cycle t.
- RUN:
  - The divider increments each cycle. A tick occurs when count==div_q; the count then wraps to 0.
  - Each tick toggles sclk_o and increments the edge counter k (1..2N). Odd k is a leading edge; even k is a trailing edge.
  - Edge k is visible at cycle t+1+k*(div_q+1). Strobes are coincident with the visible sclk_o change.
  - cpha=0: sample_o on every leading edge; shift_o on every trailing edge except edge 2N.
  - cpha=1: shift_o on every leading edge; sample_o on every trailing edge.
  - bit_idx_o increments in the same cycle each trailing edge becomes visible.
  - On edge 2N: done_o=1 and busy_o=0 in that same visible cycle, and the FSM returns to IDLE. A new start_i is accepted in the done_o cycle.
- div_q=0 gives sclk = clk_i/2. The maximum div gives a half-period of 2^DIV_W cycles; the counter width is DIV_W with no overflow.
- Changes on the config inputs while busy_o=1 are ignored.
- start_i while busy_o=1 is ignored.
- stop_i in RUN takes effect the next cycle: FSM goes to IDLE, sclk_o=cpol_q, busy_o=0, no done_o, and no strobes in that cycle.
- stop_i and start_i together in IDLE: stop wins and nothing starts.
- Reset asserted mid-transfer immediately forces the reset values.
- sample_o and shift_o are never asserted in the same cycle.

Optional Feature:
- Macro SPI_SCLK_CS_EN adds the output port cs_no (1 bit, reset 1).
- With the macro defined:
  - cs_no=0 from t+1.
  - A lead phase of one half-period (div_q+1 cycles) precedes edge 1, so all edges shift by div_q+1.
  - After edge 2N, a hold phase of one half-period follows. Then done_o=1, busy_o=0 and cs_no=1 in the same cycle.
  - stop_i sets cs_no=1 on the next cycle.
- Without the macro: no cs_no port, and timing is exactly as in Behaviour.

Test Plan:
- Mode 0, div=1, nbits=8, start at t -> sclk_o rises at t+3 and toggles every 2 cycles; 8 sample_o strobes on rising edges; 7 shift_o strobes; done_o at t+33; bit_idx_o=8 at done.
- Mode 3 (cpol=1, cpha=1), div=0, nbits=4 -> sclk_o idles 1, first fall at t+2; shift_o at t+2,4,6,8; sample_o at t+3,5,7,9; done_o with busy_o=0 at t+9.
- nbits=0, div=2 -> behaves as 1 bit: 2 edges, done_o at t+7.
- stop_i during bit 3 of an 8-bit transfer -> next cycle busy_o=0 and sclk_o=cpol; no done_o; a further start_i runs a full clean transfer.
- start_i asserted in the done_o cycle -> back-to-back transfer with busy_o=1 the following cycle. start_i while busy -> ignored. start_i with stop_i in IDLE -> ignored.
- SPI_SCLK_CS_EN, div=1, nbits=2 -> cs_no low at t+1, first edge at t+5, done_o and cs_no high at t+15. Reset mid-transfer -> cs_no=1 and all outputs at reset values immediately.
